// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg : shared widths and encodings for the 16-bit encryption CPU pipeline
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC2  = 2'b10
  } result_src_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if : data-memory req/ack bus between the memory stage and the RAM
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface mem_stage_if;
  import cpu_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );

endinterface

`default_nettype wire

// File: rtl/MEM_WB_Reg.sv
// -----------------------------------------------------------------------------
// MEM_WB_Reg : MEM/WB pipeline register; a bubble clears only the control fields
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module MEM_WB_Reg
  import cpu_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              bubble_i,
  input  wire logic              regWrite_i,
  input  wire logic [1:0]        resultSrc_i,
  input  wire logic [DATA_W-1:0] aluRes_i,
  input  wire logic [DATA_W-1:0] readData_i,
  input  wire logic [DATA_W-1:0] PCPlus2_i,
  input  wire logic [REG_W-1:0]  Rd_i,
  output logic                   regWrite_o,
  output logic [1:0]             resultSrc_o,
  output logic [DATA_W-1:0]      aluRes_o,
  output logic [DATA_W-1:0]      readData_o,
  output logic [DATA_W-1:0]      PCPlus2_o,
  output logic [REG_W-1:0]       Rd_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      regWrite_o  <= 1'b0;
      resultSrc_o <= 2'b00;
      aluRes_o    <= '0;
      readData_o  <= '0;
      PCPlus2_o   <= '0;
      Rd_o        <= '0;
    end else if (bubble_i) begin
      regWrite_o  <= 1'b0;
      resultSrc_o <= 2'b00;
    end else begin
      regWrite_o  <= regWrite_i;
      resultSrc_o <= resultSrc_i;
      aluRes_o    <= aluRes_i;
      readData_o  <= readData_i;
      PCPlus2_o   <= PCPlus2_i;
      Rd_o        <= Rd_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage : variable-latency data-memory access with pipeline stall and timeout
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module mem_stage
  import cpu_pkg::*;
#(
  parameter int         TIMEOUT  = 16,
  parameter logic [1:0] LOAD_SEL = 2'b01
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              regWriteM,
  input  wire logic              memWriteM,
  input  wire logic [1:0]        resultSrcM,
  input  wire logic [DATA_W-1:0] aluResM,
  input  wire logic [DATA_W-1:0] writeDataM,
  input  wire logic [DATA_W-1:0] PCPlus2M,
  input  wire logic [REG_W-1:0]  RdM,
  mem_stage_if.master            dmem,
  output logic                   stallM,
  output logic                   mem_err,
  output logic                   regWriteW,
  output logic [1:0]             resultSrcW,
  output logic [DATA_W-1:0]      aluResW,
  output logic [DATA_W-1:0]      readDataW,
  output logic [DATA_W-1:0]      PCPlus2W,
  output logic [REG_W-1:0]       RdW
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_WAIT = WAIT;
  localparam logic [7:0] C_LAST  = 8'(TIMEOUT - 1);

  logic [0:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              err_q, err_d;

  logic              is_load, mem_op;
  logic              req_w, stall_w, pass_w, ld_done_w;
  logic [DATA_W-1:0] addr_w, wdata_w, rdata_w;
  logic              we_w;

  assign is_load = (resultSrcM == LOAD_SEL);
  assign mem_op  = memWriteM | is_load;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    err_d     = err_q;
    req_w     = 1'b0;
    stall_w   = 1'b0;
    pass_w    = 1'b0;
    ld_done_w = 1'b0;
    addr_w    = aluResM;
    wdata_w   = writeDataM;
    we_w      = memWriteM;
    case (state_q)
      ST_IDLE: begin
        req_w = mem_op;
        if (mem_op && !dmem.dmem_ack) begin
          stall_w = 1'b1;
          state_d = ST_WAIT;
          cnt_d   = 8'd0;
          addr_d  = aluResM;
          wdata_d = writeDataM;
          we_d    = memWriteM;
        end else begin
          pass_w    = 1'b1;
          ld_done_w = is_load && dmem.dmem_ack;
        end
      end
      ST_WAIT: begin
        req_w   = 1'b1;
        addr_w  = addr_q;
        wdata_w = wdata_q;
        we_w    = we_q;
        if (dmem.dmem_ack) begin
          // Ack beats the timeout when both land in the same cycle.
          state_d   = ST_IDLE;
          pass_w    = 1'b1;
          ld_done_w = is_load;
        end else if (cnt_q == C_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          stall_w = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign dmem.dmem_req   = req_w & ~rst;
  assign dmem.dmem_we    = we_w;
  assign dmem.dmem_addr  = addr_w;
  assign dmem.dmem_wdata = wdata_w;
  assign stallM          = stall_w & ~rst;
  assign mem_err         = err_q;
  assign rdata_w         = ld_done_w ? dmem.dmem_rdata : readDataW;

  MEM_WB_Reg u_mem_wb (
    .clk         (clk),
    .rst         (rst),
    .bubble_i    (~pass_w),
    .regWrite_i  (regWriteM),
    .resultSrc_i (resultSrcM),
    .aluRes_i    (aluResM),
    .readData_i  (rdata_w),
    .PCPlus2_i   (PCPlus2M),
    .Rd_i        (RdM),
    .regWrite_o  (regWriteW),
    .resultSrc_o (resultSrcW),
    .aluRes_o    (aluResW),
    .readData_o  (readDataW),
    .PCPlus2_o   (PCPlus2W),
    .Rd_o        (RdW)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage : randomized bench for mem_stage against an instruction-level model
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;
  import cpu_pkg::*;

  localparam int TO    = 4;
  localparam int NEVER = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        regWriteM, memWriteM;
  logic [1:0]  resultSrcM;
  logic [15:0] aluResM, writeDataM, PCPlus2M;
  logic [3:0]  RdM;
  logic        stallM, mem_err, regWriteW;
  logic [1:0]  resultSrcW;
  logic [15:0] aluResW, readDataW, PCPlus2W;
  logic [3:0]  RdW;

  always #5 clk = ~clk;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT(TO), .LOAD_SEL(2'b01)) dut (
    .clk        (clk),
    .rst        (rst),
    .regWriteM  (regWriteM),
    .memWriteM  (memWriteM),
    .resultSrcM (resultSrcM),
    .aluResM    (aluResM),
    .writeDataM (writeDataM),
    .PCPlus2M   (PCPlus2M),
    .RdM        (RdM),
    .dmem       (bus),
    .stallM     (stallM),
    .mem_err    (mem_err),
    .regWriteW  (regWriteW),
    .resultSrcW (resultSrcW),
    .aluResW    (aluResW),
    .readDataW  (readDataW),
    .PCPlus2W   (PCPlus2W),
    .RdW        (RdW)
  );

  int checks = 0;
  int passed = 0;

  // Instruction currently held in EX/MEM and the memory's planned ack latency.
  logic        c_rw, c_mw;
  logic [1:0]  c_rs;
  logic [15:0] c_alu, c_wd, c_pc;
  logic [3:0]  c_rd;
  int          c_lat, age, stall_seen;
  bit          use_force = 1'b0;
  logic [15:0] force_rdata = 16'h0;

  // Expected MEM/WB contents and sticky error.
  logic        e_rw, e_err;
  logic [1:0]  e_rs;
  logic [15:0] e_alu, e_rdata, e_pc;
  logic [3:0]  e_rd;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
  endtask

  task automatic present(input logic rw, input logic mw, input logic [1:0] rs,
                         input logic [15:0] alu, input logic [15:0] wd,
                         input logic [15:0] pc, input logic [3:0] rd, input int lat);
    c_rw = rw; c_mw = mw; c_rs = rs; c_alu = alu; c_wd = wd; c_pc = pc; c_rd = rd;
    c_lat = lat; age = 0; stall_seen = 0;
    regWriteM = rw; memWriteM = mw; resultSrcM = rs;
    aluResM = alu; writeDataM = wd; PCPlus2M = pc; RdM = rd;
  endtask

  task automatic cycle(output bit fin);
    bit memop, is_load, done, abort, e_stall;
    logic [15:0] rd_v;
    memop   = c_mw || (c_rs == 2'b01);
    is_load = (c_rs == 2'b01) && !c_mw;
    rd_v    = use_force ? force_rdata : 16'($urandom);
    bus.dmem_ack   = memop ? (age == c_lat) : ($urandom_range(0, 3) == 0);
    bus.dmem_rdata = rd_v;
    #1;
    e_stall = memop && (age < c_lat) && (age < TO);
    done    = !memop || (age == c_lat);
    abort   = memop && !done && (age == TO);
    check("stallM", stallM, e_stall);
    check("dmem_req", bus.dmem_req, memop);
    if (memop) begin
      check("dmem_addr", bus.dmem_addr, c_alu);
      check("dmem_wdata", bus.dmem_wdata, c_wd);
      check("dmem_we", bus.dmem_we, c_mw);
    end
    if (stallM) stall_seen++;
    if (done) begin
      e_rw = c_rw; e_rs = c_rs; e_alu = c_alu; e_pc = c_pc; e_rd = c_rd;
      if (is_load) e_rdata = rd_v;
    end else begin
      e_rw = 1'b0; e_rs = 2'b00;
    end
    if (abort) e_err = 1'b1;
    @(posedge clk); #1;
    check("regWriteW", regWriteW, e_rw);
    check("resultSrcW", resultSrcW, e_rs);
    check("aluResW", aluResW, e_alu);
    check("readDataW", readDataW, e_rdata);
    check("PCPlus2W", PCPlus2W, e_pc);
    check("RdW", RdW, e_rd);
    check("mem_err", mem_err, e_err);
    age++;
    fin = done || abort;
  endtask

  task automatic run_inst();
    bit fin;
    for (int i = 0; i < TO + 2; i++) begin
      cycle(fin);
      if (fin) return;
    end
    check("inst_retire_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset(input bit late_ack);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    present(1'b0, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 4'h0, 0);
    bus.dmem_ack = late_ack;
    #1;
    check("rst_req", bus.dmem_req, 1'b0);
    check("rst_stall", stallM, 1'b0);
    check("rst_regWriteW", regWriteW, 1'b0);
    check("rst_resultSrcW", resultSrcW, 2'b00);
    check("rst_aluResW", aluResW, 16'h0);
    check("rst_readDataW", readDataW, 16'h0);
    check("rst_PCPlus2W", PCPlus2W, 16'h0);
    check("rst_RdW", RdW, 4'h0);
    check("rst_mem_err", mem_err, 1'b0);
    @(posedge clk); #1;
    check("post_rst_readDataW", readDataW, 16'h0);
    check("post_rst_regWriteW", regWriteW, 1'b0);
    bus.dmem_ack = 1'b0;
    e_rw = 0; e_rs = 0; e_alu = 0; e_rdata = 0; e_pc = 0; e_rd = 0; e_err = 0;
  endtask

  task automatic random_inst();
    int kind, r, lat;
    logic [1:0] rs;
    kind = $urandom_range(0, 2);
    r    = $urandom_range(0, 9);
    lat  = (r <= 5) ? (r % 4) : (r <= 7) ? TO : (r == 8) ? TO - 1 : NEVER;
    case (kind)
      0: begin
        rs = 2'($urandom_range(0, 3));
        if (rs == 2'b01) rs = 2'b00;
        present(1'($urandom), 1'b0, rs, 16'($urandom), 16'($urandom),
                16'($urandom), 4'($urandom), 0);
      end
      1: present(1'($urandom), 1'b0, 2'b01, 16'($urandom), 16'($urandom),
                 16'($urandom), 4'($urandom), lat);
      default: present(1'($urandom), 1'b1, ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10,
                       16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom), lat);
    endcase
  endtask

  initial begin
    bit fin;
    present(1'b0, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 4'h0, 0);
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 16'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);

    // Zero-wait load
    use_force = 1'b1; force_rdata = 16'hBEEF;
    present(1'b1, 1'b0, 2'b01, 16'h0040, 16'h1111, 16'h0102, 4'h5, 0);
    run_inst();
    use_force = 1'b0;
    check("zw_readDataW", readDataW, 16'hBEEF);
    check("zw_RdW", RdW, 4'h5);
    check("zw_regWriteW", regWriteW, 1'b1);
    check("zw_stall_cycles", stall_seen, 0);

    // Store acked on its third cycle
    present(1'b0, 1'b1, 2'b00, 16'h0012, 16'hA5A5, 16'h0200, 4'h3, 2);
    run_inst();
    check("st_stall_cycles", stall_seen, 2);
    check("st_aluResW", aluResW, 16'h0012);

    // Delayed load followed by an ALU op
    present(1'b1, 1'b0, 2'b01, 16'h0080, 16'h0, 16'h0300, 4'h7, 3);
    run_inst();
    check("ld3_stall_cycles", stall_seen, 3);
    present(1'b1, 1'b0, 2'b00, 16'h7777, 16'h0, 16'h0302, 4'h9, 0);
    run_inst();
    check("alu_aluResW", aluResW, 16'h7777);
    check("alu_RdW", RdW, 4'h9);
    check("alu_stall_cycles", stall_seen, 0);

    // Ack exactly at the timeout boundary
    present(1'b1, 1'b0, 2'b01, 16'h00A0, 16'h0, 16'h0400, 4'h2, TO);
    run_inst();
    check("bnd_stall_cycles", stall_seen, 4);
    check("bnd_mem_err", mem_err, 1'b0);
    check("bnd_regWriteW", regWriteW, 1'b1);

    // Timeout abort, then the next instruction proceeds with the error sticky
    present(1'b1, 1'b0, 2'b01, 16'h00B0, 16'h0, 16'h0500, 4'h4, NEVER);
    run_inst();
    check("to_stall_cycles", stall_seen, 4);
    check("to_mem_err", mem_err, 1'b1);
    check("to_regWriteW", regWriteW, 1'b0);
    present(1'b1, 1'b0, 2'b10, 16'h1234, 16'h0, 16'h0502, 4'hC, 0);
    run_inst();
    check("to_next_PCPlus2W", PCPlus2W, 16'h0502);
    check("to_err_sticky", mem_err, 1'b1);

    // Reset in the second WAIT cycle with a late ack afterwards
    present(1'b1, 1'b0, 2'b01, 16'h00C0, 16'h0, 16'h0600, 4'h6, NEVER);
    cycle(fin);
    cycle(fin);
    do_reset(1'b1);

    for (int n = 0; n < 400; n++) begin
      random_inst();
      run_inst();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 16-bit encryption CPU pipeline. It sits directly downstream of the execute stage's EX/MEM register.
- It consumes regWriteM, memWriteM, resultSrcM, aluResM, writeDataM, PCPlus2M and RdM.
- It performs variable-latency data-memory accesses over a req/ack handshake and stalls the pipeline while an access is outstanding.
- It drives the MEM/WB register that feeds writeback.

Parameters:
- TIMEOUT, 16, maximum WAIT cycles before an access is aborted (valid range 1..255).
- LOAD_SEL, 2'b01, resultSrc encoding that identifies a load.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- regWriteM  in  1  register-write enable from EX/MEM.
- memWriteM  in  1  store enable from EX/MEM.
- resultSrcM  in  2  writeback select from EX/MEM.
- aluResM  in  16  ALU result; this is the word address for loads and stores.
- writeDataM  in  16  store data.
- PCPlus2M  in  16  PC+2.
- RdM  in  4  destination register.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write strobe.
- dmem_addr  out  16  word address.
- dmem_wdata  out  16  store data.
- dmem_rdata  in  16  load data, valid when dmem_ack=1.
- dmem_ack  in  1  single-cycle completion pulse.
- stallM  out  1  freeze request for IF/ID/EX and the EX/MEM register.
- mem_err  out  1  sticky timeout flag.
- regWriteW  out  1  registered writeback enable.
- resultSrcW  out  2  registered writeback select.
- aluResW  out  16  registered ALU result.
- readDataW  out  16  registered load data.
- PCPlus2W  out  16  registered PC+2.
- RdW  out  4  registered destination register.

Behaviour:
- memOp = memWriteM | (resultSrcM==LOAD_SEL).
- **FSM states:** IDLE and WAIT.
- **IDLE:**
  - dmem_req = memOp (combinational).
  - dmem_addr, dmem_wdata and dmem_we are driven directly from aluResM, writeDataM and memWriteM.
  - If memOp & dmem_ack, the access completes in the same cycle with stallM=0.
  - If memOp & !dmem_ack, the FSM captures addr, wdata and we into holding registers, moves to WAIT, asserts stallM=1 and clears the timeout counter.
  - If no memOp, the instruction passes through with zero added latency.
- **WAIT:**
  - dmem_req=1, with dmem_addr, dmem_wdata and dmem_we taken from the holding registers.
  - stallM = !dmem_ack. The counter increments each cycle without ack.
  - On ack: complete the access, return to IDLE, stallM=0 in that cycle.
  - On counter==TIMEOUT-1 with no ack: abort. Drop req next cycle, set mem_err, set stallM=0, write a bubble into MEM/WB, return to IDLE.
  - An ack arriving in the same cycle as the timeout wins: the access completes normally and mem_err stays 0.
- **MEM/WB register** (updates every cycle):
  - When stallM=1: load a bubble (regWriteW=0, resultSrcW=0, others hold their previous value). EX/MEM is frozen upstream, so the instruction is not lost.
  - On completion or pass-through: capture regWriteM, resultSrcM, aluResM, PCPlus2M and RdM.
  - readDataW = dmem_rdata for a completing load; otherwise readDataW holds its previous value.
  - On abort: bubble only; the faulting instruction is dropped and mem_err is raised.
- **Store writeback:** a store with regWriteM=1 is legal; the register write occurs after the ack.
- **mem_err:** sticky; cleared only by rst.
- **Ack outside an access:** dmem_ack seen while no access is outstanding (IDLE and !memOp) is ignored.
- **Reset:**
  - FSM=IDLE, counter=0, holding registers=0, mem_err=0.
  - All W outputs=0, dmem_req=0, stallM=0.
  - Reset during WAIT abandons the access with no writeback and no error.
- **Latency:** one cycle MEM→W plus N wait cycles, where N is the number of cycles before ack.

Decomposition:
- Shared package cpu_pkg:
  - typedef for the resultSrc encodings (ALU, LOAD, PC2).
  - state enum mem_state_t {IDLE, WAIT}.
  - localparam for the word width (16) and register-address width (4).
- One sub-module, MEM_WB_Reg, with the same style as the existing stage registers. Its ports are a bubble input plus the in/out pairs listed above. It holds the writeback fields.
- The FSM, timeout counter and holding registers live in mem_stage.

Test Plan:
- **Zero-wait load:** resultSrcM=01, aluResM=0x0040, ack in the same cycle with rdata=0xBEEF → stallM never rises; next cycle readDataW=0xBEEF, RdW=RdM, regWriteW=1.
- **3-cycle store:** memWriteM=1, addr=0x0012, wdata=0xA5A5, ack on the 3rd cycle → stallM=1 for 2 cycles; dmem_addr/wdata/we stay stable throughout; W receives bubbles (regWriteW=0) during the stall, then the store's fields once acked.
- **ALU op (resultSrcM=00) after a delayed load:** dmem_req stays 0 for the ALU op; it reaches W with zero added latency once the load completes.
- **Timeout:** TIMEOUT=4, load with no ack → stallM high for 4 cycles; mem_err=1 from the next cycle; W shows a bubble; the following instruction proceeds; mem_err persists until rst.
- **Ack at the timeout boundary:** ack on cycle TIMEOUT-1 → normal completion, mem_err=0.
- **Reset mid-WAIT:** rst asserted in cycle 2 of WAIT → next cycle dmem_req=0, stallM=0, all W outputs=0, mem_err=0; a late ack afterwards has no effect.
